// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time loader that streams bytes into the instruction memory.
//            Build option IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_ck
);

    // One extra index bit lets idx reach MAX_WORDS after the last write.
    localparam int          IDX_W = ADDR_W - 1;
    localparam logic [15:0] C_MAX = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_BYTE  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CK  = 3'd6
`endif
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bcnt;
    logic [31:0]      word;

    logic             w_xfer;
    logic [15:0]      w_n;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_last;

    assign w_xfer    = rx_valid && rx_ready;
    assign w_n       = {rx_data, len_lo};
    assign w_idx_inc = idx + 1'b1;
    assign w_last    = (16'(w_idx_inc) == len);

    assign imem_we  = (state == ST_WRITE);
    assign done     = (state == ST_DONE);
    assign busy     = (state != ST_IDLE);
    assign cpu_hold = busy && !done;

    always_comb begin
        next_state = state;
        rx_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_HDR0;
            end
            ST_HDR0: begin
                rx_ready = 1'b1;
                if (w_xfer) next_state = ST_HDR1;
            end
            ST_HDR1: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
                    if (w_n == 16'd0 || w_n > C_MAX) next_state = ST_DONE;
                    else                             next_state = ST_BYTE;
                end
            end
            ST_BYTE: begin
                rx_ready = 1'b1;
                if (w_xfer && bcnt == 2'd3) next_state = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                next_state = w_last ? ST_CK : ST_BYTE;
`else
                next_state = w_last ? ST_DONE : ST_BYTE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CK: begin
                rx_ready = 1'b1;
                if (w_xfer) next_state = ST_DONE;
            end
`endif
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] ck;
`else
    assign err_ck = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_lo    <= '0;
            len       <= '0;
            idx       <= '0;
            bcnt      <= '0;
            word      <= '0;
            imem_addr <= '0;
            imem_wd   <= '0;
            err_len   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck        <= '0;
            err_ck    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        bcnt    <= '0;
                        err_len <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        ck      <= '0;
                        err_ck  <= 1'b0;
`endif
                    end
                end
                ST_HDR0: begin
                    if (w_xfer) len_lo <= rx_data;
                end
                ST_HDR1: begin
                    if (w_xfer) begin
                        len <= w_n;
                        if (w_n > C_MAX) err_len <= 1'b1;
                    end
                end
                ST_BYTE: begin
                    // Little-endian assembly: bytes enter at the top and shift down.
                    if (w_xfer) begin
                        word <= {rx_data, word[31:8]};
                        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        ck   <= ck ^ rx_data;
`endif
                        if (bcnt == 2'd3) begin
                            imem_addr <= {idx[IDX_W-2:0], 2'b00};
                            imem_wd   <= {rx_data, word[31:8]};
                        end
                    end
                end
                ST_WRITE: idx <= w_idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CK: begin
                    if (w_xfer && rx_data != ck) err_ck <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized byte streams, queue-based expected writes/done events.
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err_len;
    logic              err_ck;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .err_len(err_len), .err_ck(err_ck)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] wd; } wr_t;
    typedef struct { logic el; logic ec; } dn_t;

    wr_t         exp_wr[$];
    dn_t         exp_dn[$];
    logic [31:0] words[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write and done pulse is matched against the scoreboard.
    wr_t mon_w;
    dn_t mon_d;
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                check("we_excludes_ready", !rx_ready, 64'(rx_ready), 64'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 1'b0, 64'(imem_addr), 64'd0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("write_addr", imem_addr == mon_w.addr, 64'(imem_addr), 64'(mon_w.addr));
                    check("write_data", imem_wd == mon_w.wd, 64'(imem_wd), 64'(mon_w.wd));
                end
            end
            if (done) begin
                check("done_cpu_hold", !cpu_hold, 64'(cpu_hold), 64'd0);
                if (exp_dn.size() == 0) begin
                    check("unexpected_done", 1'b0, 64'd1, 64'd0);
                end else begin
                    mon_d = exp_dn.pop_front();
                    check("done_err_len", err_len == mon_d.el, 64'(err_len), 64'(mon_d.el));
                    check("done_err_ck", err_ck == mon_d.ec, 64'(err_ck), 64'(mon_d.ec));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                break;
            end
            t++;
            if (t > 200) begin
                check("byte_accept_timeout", 1'b0, 64'(b), 64'd0);
                rx_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Reference: N words, little-endian bytes, address 4*i, optional XOR checksum.
    task automatic run_load(input int n, input bit bad_ck, input int gapmax, input int start_at);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bit         in_range;
        dn_t        d;
        int         t;
        in_range = (n >= 1) && (n <= MAX_WORDS);
        x = 8'h00;
        bytes.push_back(8'(n));
        bytes.push_back(8'(n >> 8));
        if (in_range) begin
            for (int i = 0; i < n; i++) begin
                exp_wr.push_back('{addr: ADDR_W'(i * 4), wd: words[i]});
                for (int k = 0; k < 4; k++) begin
                    bytes.push_back(8'(words[i] >> (8 * k)));
                    x = x ^ 8'(words[i] >> (8 * k));
                end
            end
            if (CK_EN) bytes.push_back(bad_ck ? (x ^ 8'h01) : x);
        end
        d.el = (n > MAX_WORDS);
        d.ec = CK_EN && in_range && bad_ck;
        exp_dn.push_back(d);

        pulse_start();
        @(negedge clk);
        check("load_hold", busy && cpu_hold, 64'({busy, cpu_hold}), 64'h3);
        @(posedge clk); #1;
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(bytes[i], $urandom_range(0, gapmax));
        end
        t = 0;
        while (busy && t < 100) begin @(posedge clk); #1; t++; end
        check("load_finish", !busy, 64'(busy), 64'd0);
        check("writes_drained", exp_wr.size() == 0, 64'(exp_wr.size()), 64'd0);
        check("done_seen", exp_dn.size() == 0, 64'(exp_dn.size()), 64'd0);
        exp_wr.delete();
        exp_dn.delete();
    endtask

    initial begin
        #1;
        check("reset_outputs",
              {imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err_len, err_ck, rx_ready} == '0,
              64'({imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err_len, err_ck, rx_ready}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        words = '{32'h00100513, 32'h00200593};
        run_load(2, 1'b0, 0, -1);
        run_load(2, 1'b0, 3, -1);

        run_load(0, 1'b0, 1, -1);
        run_load(257, 1'b0, 1, -1);
        check("err_len_sticky", err_len == 1'b1, 64'(err_len), 64'd1);

        rand_words(3);
        run_load(3, 1'b0, 2, 3);

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 8);
            rand_words(n);
            run_load(n, 1'($urandom_range(0, 1)), 2, -1);
        end

        rand_words(MAX_WORDS);
        run_load(MAX_WORDS, 1'b0, 0, -1);

        words = '{32'h00100513};
        run_load(1, 1'b0, 1, -1);
        run_load(1, 1'b1, 1, -1);

        // Reset in the middle of word 2: two writes land, then everything clears with no done.
        rand_words(4);
        exp_wr.push_back('{addr: ADDR_W'(0), wd: words[0]});
        exp_wr.push_back('{addr: ADDR_W'(4), wd: words[1]});
        pulse_start();
        send_byte(8'd4, 0);
        send_byte(8'd0, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(words[i / 4] >> (8 * (i % 4))), 1);
        rst_n = 1'b0;
        #1;
        check("midload_reset_outputs",
              {imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err_len, err_ck, rx_ready} == '0,
              64'({imem_we, imem_addr, imem_wd, cpu_hold, busy, done, err_len, err_ck, rx_ready}), 64'd0);
        check("midload_writes_done", exp_wr.size() == 0, 64'(exp_wr.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", !busy && !cpu_hold, 64'({busy, cpu_hold}), 64'd0);
        exp_wr.delete();

        rand_words(2);
        run_load(2, 1'b0, 2, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
